// File: rtl/alu_regfile_wb_if.sv
// Operand read, issue and ALU-result signals between decode/ALU (master)
// and the register file / writeback stage (slave).
interface alu_regfile_wb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dest;
    logic              stall;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_dest;
    logic [DATA_W-1:0] ex_result;
    logic              sb_err;

    modport master (
        output rs_addr, rt_addr, issue_valid, issue_dest, ex_valid, ex_dest, ex_result,
        input  rs_data, rt_data, stall, sb_err
    );

    modport slave (
        input  rs_addr, rt_addr, issue_valid, issue_dest, ex_valid, ex_dest, ex_result,
        output rs_data, rt_data, stall, sb_err
    );
endinterface

// File: rtl/alu_regfile_wb.sv
// Architectural register file with a one-stage writeback register, read
// bypass from that stage, and a per-register busy scoreboard driving stall.
module alu_regfile_wb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    alu_regfile_wb_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              sb_err_q, sb_err_d;
    logic              stall;
    logic              accept;

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        if (a == '0)
            return '0;
        else if (wb_valid_q && wb_addr_q == a)
            return wb_data_q;
        else
            return mem_q[a];
    endfunction

    // A result sitting in the wb stage resolves the hazard through bypass.
    function automatic logic hazard(input logic [ADDR_W-1:0] r);
        return (r != '0) && busy_q[r] && !(wb_valid_q && wb_addr_q == r);
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        stall    = 1'b0;
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        if (bus.issue_valid)
            stall = hazard(bus.rs_addr) || hazard(bus.rt_addr) || hazard(bus.issue_dest);
        accept = bus.issue_valid && !stall;
        if (wb_valid_q)
            busy_d[wb_addr_q] = 1'b0;
        // Set after clear: a newly accepted producer owns the register.
        if (accept && bus.issue_dest != '0)
            busy_d[bus.issue_dest] = 1'b1;
        if (bus.ex_valid && bus.ex_dest != '0 && !busy_q[bus.ex_dest])
            sb_err_d = 1'b1;
    end

    always_comb begin
        bus.rs_data = read_port(bus.rs_addr);
        bus.rt_data = read_port(bus.rt_addr);
    end

    assign bus.stall  = stall;
    assign bus.sb_err = sb_err_q;

    // NOTE: the array is reset because architectural state must read zero after rst, which costs a flop reset per bit instead of a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                mem_q[i] <= '0;
            busy_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
            if (wb_valid_q && wb_addr_q != '0)
                mem_q[wb_addr_q] <= wb_data_q;
            busy_q     <= busy_d;
            wb_valid_q <= bus.ex_valid && (bus.ex_dest != '0);
            wb_addr_q  <= bus.ex_dest;
            wb_data_q  <= bus.ex_result;
            sb_err_q   <= sb_err_d;
        end
    end
endmodule

// File: tb/tb_alu_regfile_wb.sv
// Directed bench for alu_regfile_wb: inputs change on the falling edge and
// outputs are compared 1 ns later, well before the next rising edge.
module tb_alu_regfile_wb;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    alu_regfile_wb_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    alu_regfile_wb #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and drive a full input vector.
    task automatic step(input logic iv, input logic [2:0] dest, input logic [2:0] rs,
                        input logic [2:0] rt, input logic exv, input logic [2:0] exd,
                        input logic [15:0] exr);
        @(negedge clk);
        bus.issue_valid = iv;
        bus.issue_dest  = dest;
        bus.rs_addr     = rs;
        bus.rt_addr     = rt;
        bus.ex_valid    = exv;
        bus.ex_dest     = exd;
        bus.ex_result   = exr;
        #1;
    endtask

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 3'd0, 3'd3, 3'd5, 1'b1, 3'd3, 16'hBEEF);
        step(1'b0, 3'd0, 3'd3, 3'd5, 1'b0, 3'd0, 16'h0000);
        rst = 1'b0;
        step(1'b0, 3'd0, 3'd3, 3'd5, 1'b0, 3'd0, 16'h0000);
        cmp("reset_rs3", bus.rs_data, 16'h0000);
        cmp("reset_rt5", bus.rt_data, 16'h0000);
        cmp("reset_stall", {15'd0, bus.stall}, 16'd0);
        cmp("reset_sb_err", {15'd0, bus.sb_err}, 16'd0);
    endtask

    task automatic test_raw();
        step(1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("raw_producer_accept", {15'd0, bus.stall}, 16'd0);
        step(1'b1, 3'd7, 3'd2, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("raw_stall_c2", {15'd0, bus.stall}, 16'd1);
        step(1'b1, 3'd7, 3'd2, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("raw_stall_c3", {15'd0, bus.stall}, 16'd1);
        step(1'b1, 3'd7, 3'd2, 3'd0, 1'b1, 3'd2, 16'h1234);
        cmp("raw_stall_ex_cycle", {15'd0, bus.stall}, 16'd1);
        step(1'b1, 3'd7, 3'd2, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("raw_unstall_wb", {15'd0, bus.stall}, 16'd0);
        cmp("raw_bypass_rs2", bus.rs_data, 16'h1234);
        // Consumer (dest 7) accepted above; retire it right away.
        step(1'b0, 3'd0, 3'd2, 3'd7, 1'b1, 3'd7, 16'h7777);
        cmp("raw_array_rs2", bus.rs_data, 16'h1234);
        cmp("raw_idle_no_stall", {15'd0, bus.stall}, 16'd0);
        step(1'b0, 3'd0, 3'd2, 3'd7, 1'b0, 3'd0, 16'h0000);
        cmp("raw_bypass_rt7", bus.rt_data, 16'h7777);
        step(1'b1, 3'd0, 3'd7, 3'd2, 1'b0, 3'd0, 16'h0000);
        cmp("raw_array_rt2", bus.rt_data, 16'h1234);
        cmp("raw_r7_free", {15'd0, bus.stall}, 16'd0);
    endtask

    task automatic test_r0();
        step(1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 3'd0, 16'hFFFF);
        step(1'b1, 3'd0, 3'd0, 3'd2, 1'b0, 3'd0, 16'h0000);
        cmp("r0_rs_zero", bus.rs_data, 16'h0000);
        cmp("r0_rt2_kept", bus.rt_data, 16'h1234);
        cmp("r0_dest0_no_stall", {15'd0, bus.stall}, 16'd0);
        step(1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("r0_no_busy", {15'd0, bus.stall}, 16'd0);
        cmp("r0_no_sb_err", {15'd0, bus.sb_err}, 16'd0);
    endtask

    task automatic test_same_edge();
        step(1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("se_issue4", {15'd0, bus.stall}, 16'd0);
        step(1'b0, 3'd0, 3'd4, 3'd0, 1'b1, 3'd4, 16'h4444);
        step(1'b1, 3'd4, 3'd4, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("se_reissue4_accept", {15'd0, bus.stall}, 16'd0);
        cmp("se_bypass4", bus.rs_data, 16'h4444);
        step(1'b1, 3'd0, 3'd4, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("se_set_wins_stall", {15'd0, bus.stall}, 16'd1);
        cmp("se_array4", bus.rs_data, 16'h4444);
        step(1'b1, 3'd0, 3'd4, 3'd0, 1'b1, 3'd4, 16'h4445);
        step(1'b1, 3'd0, 3'd4, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("se_second_bypass", bus.rs_data, 16'h4445);
        cmp("se_second_unstall", {15'd0, bus.stall}, 16'd0);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 3'd5, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000);
        step(1'b1, 3'd5, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("b2b_waw_stall", {15'd0, bus.stall}, 16'd1);
        step(1'b0, 3'd0, 3'd5, 3'd0, 1'b1, 3'd5, 16'hA1A1);
        step(1'b0, 3'd0, 3'd5, 3'd0, 1'b1, 3'd5, 16'hB2B2);
        cmp("b2b_first_bypass", bus.rs_data, 16'hA1A1);
        step(1'b0, 3'd0, 3'd5, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("b2b_second_bypass", bus.rs_data, 16'hB2B2);
        step(1'b0, 3'd0, 3'd5, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("b2b_array_second", bus.rs_data, 16'hB2B2);
        // Different destinations back-to-back.
        step(1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000);
        step(1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("b2b_issue3", {15'd0, bus.stall}, 16'd0);
        step(1'b0, 3'd0, 3'd2, 3'd3, 1'b1, 3'd2, 16'h2222);
        step(1'b0, 3'd0, 3'd2, 3'd3, 1'b1, 3'd3, 16'h3333);
        step(1'b0, 3'd0, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0000);
        step(1'b1, 3'd0, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0000);
        cmp("b2b_diff_r2", bus.rs_data, 16'h2222);
        cmp("b2b_diff_r3", bus.rt_data, 16'h3333);
        cmp("b2b_diff_free", {15'd0, bus.stall}, 16'd0);
        cmp("b2b_no_sb_err", {15'd0, bus.sb_err}, 16'd0);
    endtask

    task automatic test_sb_err();
        step(1'b0, 3'd0, 3'd6, 3'd0, 1'b1, 3'd6, 16'h00AA);
        cmp("sb_err_before_edge", {15'd0, bus.sb_err}, 16'd0);
        step(1'b0, 3'd0, 3'd6, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("sb_err_set", {15'd0, bus.sb_err}, 16'd1);
        cmp("sb_err_bypass6", bus.rs_data, 16'h00AA);
        step(1'b0, 3'd0, 3'd6, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("sb_err_array6", bus.rs_data, 16'h00AA);
        step(1'b0, 3'd0, 3'd6, 3'd0, 1'b0, 3'd0, 16'h0000);
        cmp("sb_err_sticky", {15'd0, bus.sb_err}, 16'd1);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000);
        step(1'b1, 3'd3, 3'd0, 3'd0, 1'b1, 3'd1, 16'h1111);
        step(1'b1, 3'd0, 3'd1, 3'd3, 1'b0, 3'd0, 16'h0000);
        cmp("rm_pre_bypass1", bus.rs_data, 16'h1111);
        cmp("rm_pre_stall3", {15'd0, bus.stall}, 16'd1);
        #2 rst = 1'b1;
        #1;
        cmp("rm_async_rs1", bus.rs_data, 16'h0000);
        cmp("rm_async_stall", {15'd0, bus.stall}, 16'd0);
        cmp("rm_async_sb_err", {15'd0, bus.sb_err}, 16'd0);
        step(1'b1, 3'd0, 3'd1, 3'd3, 1'b0, 3'd0, 16'h0000);
        rst = 1'b0;
        step(1'b1, 3'd0, 3'd1, 3'd3, 1'b0, 3'd0, 16'h0000);
        cmp("rm_after_rs1", bus.rs_data, 16'h0000);
        cmp("rm_after_busy_clear", {15'd0, bus.stall}, 16'd0);
    endtask

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_dest  = '0;
        bus.rs_addr     = '0;
        bus.rt_addr     = '0;
        bus.ex_valid    = 1'b0;
        bus.ex_dest     = '0;
        bus.ex_result   = '0;
        test_reset();
        test_raw();
        test_r0();
        test_same_edge();
        test_back_to_back();
        test_sb_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_regfile_wb.md
# alu_regfile_wb

- Register file and writeback stage that is the other end of the ALU datapath.
- It supplies the ALU's 16-bit Rs/Rt operands through two read ports and accepts the ALU's Rd result through a one-stage writeback register.
- A per-register busy scoreboard generates an issue stall for read-after-write and write-after-write hazards.
- It sits between decode/issue and the ALU in the pipelined processor, and owns all architectural register state.

## Interface
Parameters:
- DATA_W, 16, register and operand width
- ADDR_W, 3, register index width (2**ADDR_W registers; R0 hardwired to zero)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- rs_addr  input  ADDR_W  read port A index
- rt_addr  input  ADDR_W  read port B index
- rs_data  output  DATA_W  operand Rs to ALU (combinational read with bypass)
- rt_data  output  DATA_W  operand Rt to ALU (combinational read with bypass)
- issue_valid  input  1  decode requests issue of an instruction reading rs/rt and writing issue_dest
- issue_dest  input  ADDR_W  destination of the issuing instruction
- stall  output  1  issue refused this cycle; decode holds its request
- ex_valid  input  1  ALU result present this cycle
- ex_dest  input  ADDR_W  destination of the ALU result
- ex_result  input  DATA_W  ALU Rd value
- sb_err  output  1  sticky: result arrived for a register not marked busy

## Operation
- Storage: 2**ADDR_W words of DATA_W bits. R0 always reads 0 and is never written.
- Writeback register (wb_valid, wb_addr, wb_data):
  - Loaded every edge from ex_valid, ex_dest, ex_result.
  - If ex_dest==0, wb_valid loads 0.
- Commit: when wb_valid=1, at the next edge:
  - array[wb_addr] <= wb_data;
  - busy[wb_addr] is cleared, unless the same register is being set on that edge.
- Read bypass, per port and independently:
  - If addr==0, data=0.
  - Else if wb_valid and wb_addr==addr, data=wb_data.
  - Else data=array[addr].
- Scoreboard:
  - Per-register busy bit.
  - An issue is accepted when issue_valid=1 and stall=0.
  - On accept with issue_dest!=0, busy[issue_dest] is set at the edge.
  - Set and clear of the same register on the same edge: set wins, because the new producer owns it.
- Hazard for register r: busy[r]=1 and not (wb_valid and wb_addr==r).
  - Treat r=0 as never hazardous.
- stall = issue_valid and (hazard(rs_addr) or hazard(rt_addr) or hazard(issue_dest)).
  - stall is 0 whenever issue_valid=0.
- sb_err is set at the edge when ex_valid=1, ex_dest!=0 and busy[ex_dest]=0. It is cleared only by rst.
  - On the sb_err condition the result is still written back normally.
- Arithmetic: none. Data passes through unmodified at full DATA_W; there is no truncation or extension.

## Timing
- Reset, asynchronous on rst rising, effective immediately:
  - all array words = 0, all busy = 0, wb_valid = 0, wb_addr = 0, wb_data = 0, sb_err = 0;
  - consequently rs_data = rt_data = 0 and stall = 0 while rst is held.
- Reset during outstanding results discards them: busy is cleared and the wb stage is emptied.
- Read latency: 0 cycles; rs_data/rt_data are combinational from the addresses and state.
- Result latency, with ex_valid at cycle N:
  - visible via bypass in cycle N+1;
  - in the array and busy cleared from cycle N+2.
- Issue-to-unstall latency for a dependent instruction:
  - the consumer may issue in the cycle the producer's result sits in the wb stage (N+1);
  - it is not stalled after that.
- Back-to-back results to the same register (ex at N and N+1):
  - the second value is bypassed in N+2;
  - the array holds the second value from N+3.
- Back-to-back results to different registers: each commits one cycle after its wb cycle, with no loss.
- stall is combinational from the inputs and current state; decode must sample it in the same cycle it drives issue_valid.

## Test plan
- Reset then read: assert rst, preload by writeback, deassert → rs_addr=3, rt_addr=5 read 0x0000 before any writes; stall=0; sb_err=0.
- RAW stall/bypass:
  - issue dest=2 accepted at cycle 1;
  - next issue reading rs=2 → stall=1 until ex_valid dest=2 result 0x1234 at cycle 4;
  - in cycle 5 stall=0 and rs_data=0x1234 via bypass;
  - array[2]=0x1234 from cycle 6.
- R0 rules: ex_valid dest=0 result 0xFFFF → wb_valid stays 0; rs_addr=0 reads 0x0000; issue_dest=0 never stalls and sets no busy bit.
- Same-edge set/clear: reg 4 result in the wb stage while a new issue with dest=4 is accepted → after the edge busy[4]=1 and a subsequent read of 4 with no new result stalls.
- Error flag: ex_valid dest=6 with busy[6]=0, result 0x00AA → sb_err=1 from the next cycle and stays 1; array[6]=0x00AA two cycles later.
- Reset mid-operation: busy[1]=1 and a result in the wb stage, assert rst asynchronously → busy cleared, wb_valid=0, rs_data(1)=0x0000 immediately, stall=0.
